// File: rtl/ref_reader_pkg.sv
// ref_reader_pkg: shared state encodings, defaults and beat-count helper for the reference reader
package ref_reader_pkg;
  localparam int ADDR_WIDTH_DEF = 25;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] PRESENT = 2'd2;
  function automatic int beats_of(input int ref_length, input int dram_width);
    return 2 * ref_length / dram_width;
  endfunction
endpackage

// File: rtl/ref_block_assembler.sv
// ref_block_assembler: collects in-order DRAM beats into one reference block, beat 0 in the LSBs
module ref_block_assembler #(
  parameter int BEATS = 4,
  parameter int DRAM_WIDTH = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        wr,
  input  logic [DRAM_WIDTH-1:0]       data,
  output logic [BEATS*DRAM_WIDTH-1:0] block,
  output logic                        full,
  output logic                        last
);
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  logic [CW-1:0] resp_cnt;
  assign last = wr && resp_cnt == CW'(BEATS - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      block <= '0;
      resp_cnt <= '0;
      full <= 1'b0;
    end else begin
      if (clr) full <= 1'b0;
      if (wr) begin
        block[resp_cnt*DRAM_WIDTH +: DRAM_WIDTH] <= data;
        resp_cnt <= last ? '0 : resp_cnt + CW'(1);
      end
      if (last) full <= 1'b1;
    end
endmodule

// File: rtl/ref_block_reader.sv
// ref_block_reader: fetches reference blocks from DRAM and hands them to the SW engine.
// REF_PREFETCH_EN: adds a second block buffer so the next block is fetched while one is presented.
module ref_block_reader
  import ref_reader_pkg::*;
#(
  parameter int REF_LENGTH = 256,
  parameter int DRAM_WIDTH = 128,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   ref_addr_in,
  input  logic [ADDR_WIDTH-1:0]   ref_length_in,
  input  logic                    ref_info_valid_in,
  output logic                    busy_out,
  output logic                    done_out,
  output logic [ADDR_WIDTH-1:0]   dram_rd_addr_out,
  output logic                    dram_rd_req_out,
  input  logic                    dram_rd_ack_in,
  input  logic [DRAM_WIDTH-1:0]   dram_rd_data_in,
  input  logic                    dram_rd_data_valid_in,
  output logic [2*REF_LENGTH-1:0] ref_seq_block_out,
  output logic                    ref_seq_block_valid_out,
  input  logic                    ref_seq_block_rdy_in
);
  localparam int BEATS = beats_of(REF_LENGTH, DRAM_WIDTH);
  localparam int BW = 2 * REF_LENGTH;
  localparam int RW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int OW = $clog2(2 * BEATS + 1);
`ifdef REF_PREFETCH_EN
  localparam logic PF = 1'b1;
`else
  localparam logic PF = 1'b0;
`endif
  localparam int NBUF = PF ? 2 : 1;
  logic [1:0] state;
  logic [ADDR_WIDTH-1:0] addr, req_left, pres_left;
  logic [RW-1:0] req_cnt;
  logic [OW-1:0] out_cnt;
  logic req_sel, wr_sel, rd_sel;
  logic [1:0] alloc, full, last;
  logic [BW-1:0] blk [2];
  logic ack_ok, dv_ok, accept, last_any, fin;
  // a buffer is claimed by its first ack and released when its block is accepted
  assign dram_rd_req_out = state != IDLE && req_left != '0 && (req_cnt != '0 || !alloc[req_sel]);
  assign ack_ok = dram_rd_req_out && dram_rd_ack_in;
  assign dv_ok = dram_rd_data_valid_in && out_cnt != '0;
  assign accept = state == PRESENT && ref_seq_block_rdy_in;
  assign last_any = |last;
  assign fin = pres_left == ADDR_WIDTH'(1);
  assign busy_out = state != IDLE;
  assign ref_seq_block_valid_out = state == PRESENT;
  assign ref_seq_block_out = blk[rd_sel];
  assign dram_rd_addr_out = addr;
  for (genvar i = 0; i < 2; i++) begin : g_buf
    if (i < NBUF) begin : g_asm
      ref_block_assembler #(.BEATS(BEATS), .DRAM_WIDTH(DRAM_WIDTH)) u_asm (
        .clk(clk),
        .rst(rst),
        .clr(accept && rd_sel == 1'(i)),
        .wr(dv_ok && wr_sel == 1'(i)),
        .data(dram_rd_data_in),
        .block(blk[i]),
        .full(full[i]),
        .last(last[i])
      );
    end else begin : g_none
      assign blk[i] = '0;
      assign full[i] = 1'b0;
      assign last[i] = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      req_left <= '0;
      pres_left <= '0;
      req_cnt <= '0;
      out_cnt <= '0;
      req_sel <= 1'b0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      alloc <= '0;
      done_out <= 1'b0;
    end else begin
      done_out <= 1'b0;
      out_cnt <= out_cnt + OW'(ack_ok) - OW'(dv_ok);
      if (last_any) wr_sel <= wr_sel ^ PF;
      if (accept) begin
        alloc[rd_sel] <= 1'b0;
        rd_sel <= rd_sel ^ PF;
        pres_left <= pres_left - ADDR_WIDTH'(1);
      end
      if (ack_ok) begin
        addr <= addr + ADDR_WIDTH'(1);
        if (req_cnt == '0) alloc[req_sel] <= 1'b1;
        req_cnt <= req_cnt == RW'(BEATS - 1) ? '0 : req_cnt + RW'(1);
        if (req_cnt == RW'(BEATS - 1)) begin
          req_left <= req_left - ADDR_WIDTH'(1);
          req_sel <= req_sel ^ PF;
        end
      end
      if (state == IDLE && ref_info_valid_in) begin
        done_out <= ref_length_in == '0;
        state <= ref_length_in == '0 ? IDLE : FETCH;
        addr <= ref_addr_in;
        req_left <= ref_length_in;
        pres_left <= ref_length_in;
      end else if (state == FETCH && last_any) state <= PRESENT;
      else if (accept) begin
        done_out <= fin;
        state <= fin ? IDLE : (full[~rd_sel] || last_any) ? PRESENT : FETCH;
      end
    end
endmodule
